ram_stream_reader: RTL and testbench

Read-side streaming engine for the team's two-port RAM (combinational read port, synchronous write port). On a start command it walks a contiguous, wrap-around address range, fetches one word per cycle through the RAM's read port and presents the words on a valid/ready output stream with a single registered output stage. It sits between the RAM and any downstream consumer; a separate writer owns the RAM's write port.

---
 rtl/ram_stream_reader_pkg.sv | 12 +
 rtl/ram_stream_reader_ram.sv | 27 ++
 rtl/ram_stream_reader.sv | 107 ++++++++++
 tb/tb_ram_stream_reader.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_stream_reader_pkg.sv
// Shared definitions for the RAM reader, the RAM itself and the writer-side block.
package ram_stream_reader_pkg;

  localparam int unsigned default_addr_width = 3;
  localparam int unsigned default_data_width = 8;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_e;

endpackage

// File: rtl/ram_stream_reader_ram.sv
// Two-port RAM: combinational read port, synchronous write port.
module ram_stream_reader_ram
  import ram_stream_reader_pkg::*;
#(
  parameter int unsigned addr_width = default_addr_width,
  parameter int unsigned data_width = default_data_width
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [addr_width-1:0] w_addr_i,
  input  logic [data_width-1:0] w_data_i,
  input  logic [addr_width-1:0] r_addr_i,
  output logic [data_width-1:0] r_data_o
);

  logic [data_width-1:0] mem_q [2**addr_width];

  // NOTE: storage arrays are deliberately left out of reset so they map onto RAM macros.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[w_addr_i] <= w_data_i;
    end
  end

  assign r_data_o = mem_q[r_addr_i];

endmodule

// File: rtl/ram_stream_reader.sv
// Streams a wrap-around address range out of the RAM read port onto a valid/ready
// output with a single registered output stage.
module ram_stream_reader
  import ram_stream_reader_pkg::*;
#(
  parameter int unsigned addr_width = default_addr_width,
  parameter int unsigned data_width = default_data_width
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [addr_width-1:0] base_addr,
  input  logic [addr_width:0]   length,
  output logic                  busy,
  output logic                  done,
  output logic [addr_width-1:0] r_addr,
  input  logic [data_width-1:0] r_data,
  output logic [data_width-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready
);

  state_e                state_q, state_d;
  logic [addr_width-1:0] rd_ptr_q, rd_ptr_d;
  logic [addr_width:0]   remaining_q, remaining_d;
  logic [data_width-1:0] m_data_q, m_data_d;
  logic                  m_valid_q, m_valid_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic transfer;
  logic out_free;

  assign transfer = m_valid_q && m_ready;
  assign out_free = !m_valid_q || m_ready;

  // NOTE: every signal gets a default before the case so no latch can be inferred.
  always_comb begin
    state_d     = state_q;
    rd_ptr_d    = rd_ptr_q;
    remaining_d = remaining_q;
    m_data_d    = m_data_q;
    m_valid_d   = m_valid_q;
    busy_d      = busy_q;
    done_d      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (length != '0) begin
            rd_ptr_d    = base_addr;
            remaining_d = length;
            busy_d      = 1'b1;
            state_d     = STREAM;
          end else begin
            done_d = 1'b1;
          end
        end
      end

      STREAM: begin
        // A load also covers the case where the current word is leaving this cycle.
        if (out_free && remaining_q != '0) begin
          m_data_d    = r_data;
          m_valid_d   = 1'b1;
          rd_ptr_d    = rd_ptr_q + 1'b1;
          remaining_d = remaining_q - 1'b1;
        end else if (transfer && remaining_q == '0) begin
          m_valid_d = 1'b0;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          state_d   = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      rd_ptr_q    <= '0;
      remaining_q <= '0;
      m_data_q    <= '0;
      m_valid_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_ptr_q    <= rd_ptr_d;
      remaining_q <= remaining_d;
      m_data_q    <= m_data_d;
      m_valid_q   <= m_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign r_addr  = rd_ptr_q;
  assign m_data  = m_data_q;
  assign m_valid = m_valid_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_ram_stream_reader.sv
// Bench for ram_stream_reader driving a real two-port RAM, checked against an
// array/queue model of memory contents and expected word order.
module tb_ram_stream_reader;

  localparam int unsigned AW = 3;
  localparam int unsigned DW = 8;
  localparam int unsigned DEPTH = 2**AW;

  logic          clk;
  logic          rst;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   length;
  logic          busy;
  logic          done;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_data;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready;
  logic          we;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_data;

  logic [DW-1:0] model_mem [DEPTH];

  int checks = 0;
  int errors = 0;

  ram_stream_reader #(.addr_width(AW), .data_width(DW)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .base_addr(base_addr),
    .length   (length),
    .busy     (busy),
    .done     (done),
    .r_addr   (r_addr),
    .r_data   (r_data),
    .m_data   (m_data),
    .m_valid  (m_valid),
    .m_ready  (m_ready)
  );

  ram_stream_reader_ram #(.addr_width(AW), .data_width(DW)) ram (
    .clk     (clk),
    .we_i    (we),
    .w_addr_i(w_addr),
    .w_data_i(w_data),
    .r_addr_i(r_addr),
    .r_data_o(r_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ram_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    we = 1'b1; w_addr = a; w_data = d;
    step();
    we = 1'b0;
    model_mem[a] = d;
  endtask

  // ready_mode: 0 = always ready, 1 = random, 2 = fixed 1,0,0,1,0,1 then ready.
  // inj_cyc: cycle at which a stray start pulse is driven (-1 = none).
  // coll_cyc: cycle at which the word about to be loaded is overwritten (-1 = none).
  task automatic run_stream(input string name, input logic [AW-1:0] b, input int len,
                            input int ready_mode, input int inj_cyc,
                            input int coll_cyc, input logic [AW-1:0] coll_addr);
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] exp_w;
    logic [DW-1:0] prev_data;
    logic [AW-1:0] prev_addr;
    logic          prev_valid, prev_ready, last, r;
    int            cyc;
    int            pattern [6] = '{1, 0, 0, 1, 0, 1};

    for (int i = 0; i < len; i++) exp_q.push_back(model_mem[(int'(b) + i) % DEPTH]);

    start = 1'b1; base_addr = b; length = (AW+1)'(len);
    step();
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || m_valid !== 1'b0 || r_addr !== b) begin
      errors++;
      $display("FAIL %s launch: busy=%b m_valid=%b r_addr=%0d, required busy=1 m_valid=0 r_addr=%0d",
               name, busy, m_valid, r_addr, b);
    end

    cyc = 0; last = 1'b0; prev_valid = 1'b0; prev_ready = 1'b1;
    prev_data = '0; prev_addr = '0;
    while (!last && cyc < 200) begin
      case (ready_mode)
        0:       r = 1'b1;
        1:       r = 1'($urandom_range(0, 1));
        default: r = (cyc < 6) ? 1'(pattern[cyc]) : 1'b1;
      endcase
      m_ready = r;
      if (cyc == inj_cyc) begin
        start = 1'b1; base_addr = b + 3'd3; length = 4'd2;
      end else begin
        start = 1'b0;
      end
      if (cyc == coll_cyc) begin
        checks++;
        if (r_addr !== coll_addr) begin
          errors++;
          $display("FAIL %s collision_addr: r_addr=%0d required %0d", name, r_addr, coll_addr);
        end
        we = 1'b1; w_addr = coll_addr; w_data = 8'hAA;
      end
      checks++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        errors++;
        $display("FAIL %s busy_done cyc %0d: busy=%b done=%b required busy=1 done=0",
                 name, cyc, busy, done);
      end
      if (cyc == 1) begin
        checks++;
        if (m_valid !== 1'b1) begin
          errors++;
          $display("FAIL %s first_word_latency: m_valid=%b required 1", name, m_valid);
        end
      end
      if (prev_valid && !prev_ready) begin
        checks++;
        if (m_valid !== 1'b1 || m_data !== prev_data || r_addr !== prev_addr) begin
          errors++;
          $display("FAIL %s stall_hold cyc %0d: m_valid=%b m_data=%h r_addr=%0d required 1 %h %0d",
                   name, cyc, m_valid, m_data, r_addr, prev_data, prev_addr);
        end
      end
      if (m_valid === 1'b1 && r) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL %s extra_word: m_data=%h required no transfer", name, m_data);
        end else begin
          exp_w = exp_q.pop_front();
          if (m_data !== exp_w) begin
            errors++;
            $display("FAIL %s data: m_data=%h required %h", name, m_data, exp_w);
          end
          if (exp_q.size() == 0) last = 1'b1;
        end
      end
      prev_valid = m_valid; prev_ready = r; prev_data = m_data; prev_addr = r_addr;
      step();
      if (cyc == coll_cyc) begin
        we = 1'b0;
        model_mem[coll_addr] = 8'hAA;
      end
      cyc++;
    end
    start = 1'b0;

    checks++;
    if (!last) begin
      errors++;
      $display("FAIL %s timeout: %0d words outstanding, required 0", name, exp_q.size());
    end else if (done !== 1'b1 || busy !== 1'b0 || m_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s completion: done=%b busy=%b m_valid=%b required 1 0 0",
               name, done, busy, m_valid);
    end
  endtask

  task automatic test_reset();
    checks++;
    if (m_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || r_addr !== '0 || m_data !== '0) begin
      errors++;
      $display("FAIL reset: m_valid=%b busy=%b done=%b r_addr=%0d m_data=%h required all zero",
               m_valid, busy, done, r_addr, m_data);
    end
  endtask

  task automatic test_basic();
    run_stream("basic", 3'd2, 4, 0, -1, -1, '0);
  endtask

  task automatic test_wrap();
    run_stream("wrap", 3'd6, 4, 0, -1, -1, '0);
    run_stream("full", 3'd3, 8, 0, -1, -1, '0);
  endtask

  task automatic test_backpressure();
    run_stream("backpressure", 3'd1, 3, 2, -1, -1, '0);
  endtask

  task automatic test_zero_length();
    start = 1'b1; base_addr = 3'd5; length = '0;
    step();
    start = 1'b0;
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || m_valid !== 1'b0) begin
      errors++;
      $display("FAIL zero_len_pulse: done=%b busy=%b m_valid=%b required 1 0 0", done, busy, m_valid);
    end
    step();
    checks++;
    if (done !== 1'b0 || m_valid !== 1'b0) begin
      errors++;
      $display("FAIL zero_len_after: done=%b m_valid=%b required 0 0", done, m_valid);
    end
  endtask

  task automatic test_ignored_start();
    run_stream("ignored_start", 3'd0, 5, 0, 2, -1, '0);
  endtask

  task automatic test_back_to_back();
    run_stream("b2b_a", 3'd4, 2, 0, -1, -1, '0);
    run_stream("b2b_b", 3'd7, 3, 1, -1, -1, '0);
  endtask

  task automatic test_collision();
    run_stream("collision", 3'd4, 4, 0, -1, 1, 3'd5);
    run_stream("collision_reread", 3'd5, 1, 0, -1, -1, '0);
  endtask

  task automatic test_async_reset();
    int n = 0;
    int cyc = 0;
    start = 1'b1; base_addr = 3'd3; length = 4'd5; m_ready = 1'b1;
    step();
    start = 1'b0;
    while (n < 2 && cyc < 20) begin
      if (m_valid === 1'b1) n++;
      step();
      cyc++;
    end
    checks++;
    if (n < 2 || m_valid !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL async_pre: transfers=%0d m_valid=%b busy=%b required 2 1 1", n, m_valid, busy);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (m_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || r_addr !== '0) begin
      errors++;
      $display("FAIL async_reset: m_valid=%b busy=%b done=%b r_addr=%0d required 0 0 0 0",
               m_valid, busy, done, r_addr);
    end
    #2 rst = 1'b0;
    step();
    checks++;
    if (done !== 1'b0 || m_valid !== 1'b0) begin
      errors++;
      $display("FAIL async_no_done: done=%b m_valid=%b required 0 0", done, m_valid);
    end
    run_stream("post_reset", 3'd5, 3, 0, -1, -1, '0);
  endtask

  task automatic test_random();
    int len;
    for (int k = 0; k < 8; k++) begin
      ram_write(AW'($urandom_range(0, DEPTH-1)), DW'($urandom));
      len = $urandom_range(0, DEPTH);
      if (len == 0) test_zero_length();
      else run_stream("random", AW'($urandom_range(0, DEPTH-1)), len, 1, -1, -1, '0);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; base_addr = '0; length = '0; m_ready = 1'b0;
    we = 1'b0; w_addr = '0; w_data = '0;
    #1;
    test_reset();
    for (int i = 0; i < int'(DEPTH); i++) ram_write(AW'(i), DW'(8'h10 + i));
    #2 rst = 1'b0;
    step();
    test_basic();
    test_wrap();
    test_backpressure();
    test_zero_length();
    test_ignored_start();
    test_back_to_back();
    test_collision();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
